// File: rtl/inv_cosim_pkg.sv
// inv_cosim_pkg: shared types and constants for the inverter co-simulation checkers
package inv_cosim_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;
    localparam logic [6:0] PRBS7_SEED  = 7'h5A;
    localparam int         CNT_W_DEF   = 16;

    // x^7+x^6+1 Fibonacci step: shift left, feedback enters at bit 0
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen: loadable PRBS7 generator, newest bit presented on bit_o
module prbs7_gen
    import inv_cosim_pkg::*;
#(
    parameter logic [6:0] SEED = PRBS7_SEED
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [6:0] seed_i,
    output logic       bit_o,
    output logic [6:0] state_o
);

    logic [6:0] lfsr;

    // load wins over advance so a restart always begins from the seed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     lfsr <= SEED;
        else if (load_i) lfsr <= seed_i;
        else if (en_i)   lfsr <= prbs7_next(lfsr);
    end

    assign bit_o   = lfsr[0];
    assign state_o = lfsr;

endmodule

// File: rtl/inv_stim_checker.sv
// inv_stim_checker: PRBS7 stimulus and dual-output response checker for the clocked inverter
module inv_stim_checker
    import inv_cosim_pkg::*;
#(
    parameter int         LAT_O  = 2,
    parameter int         LAT_NO = 1,
    parameter logic [6:0] SEED   = PRBS7_SEED,
    parameter int         CNT_W  = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_vec_i,
    input  logic             out_i,
    input  logic             out_ni,
    output logic             stim_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_o
);

    localparam int HD = (LAT_O > LAT_NO) ? LAT_O : LAT_NO;

    state_t           state;
    logic [HD-1:0]    hist;
    logic [CNT_W-1:0] num_vec;
    logic [CNT_W-1:0] k;
    logic [3:0]       fcnt;
    logic             s_o;
    logic             s_no;
    logic             adv;
    logic             go;
    logic             fail;
    logic [6:0]       lfsr_unused;

    assign adv  = (state == FLUSH) || (state == RUN);
    assign go   = start_i && ((state == IDLE) || (state == DONE));
    assign fail = (s_o != ~hist[LAT_O-1]) || (s_no != ~hist[LAT_NO-1]);

    prbs7_gen #(.SEED(SEED)) u_prbs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (adv),
        .load_i  (go),
        .seed_i  (SEED),
        .bit_o   (stim_o),
        .state_o (lfsr_unused)
    );

    // register the returned outputs and track the stimulus history in step with the LFSR
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_o  <= 1'b0;
            s_no <= 1'b0;
            hist <= '0;
        end else begin
            s_o  <= out_i;
            s_no <= out_ni;
            if (adv) hist <= HD'({hist, stim_o});
        end
    end

    // run control: flush the pipeline, check num_vec vectors, then report
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_cnt_o   <= '0;
            first_err_o <= '1;
            num_vec     <= '0;
            k           <= '0;
            fcnt        <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= FLUSH;
                        busy_o      <= 1'b1;
                        pass_o      <= 1'b0;
                        num_vec     <= num_vec_i;
                        err_cnt_o   <= '0;
                        first_err_o <= '1;
                        k           <= '0;
                        fcnt        <= '0;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    if (fcnt == 4'(HD - 1)) begin
                        if (num_vec == '0) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            pass_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fail) begin
                        err_cnt_o <= (&err_cnt_o) ? err_cnt_o : err_cnt_o + 1'b1;
                        if (err_cnt_o == '0) first_err_o <= k;
                    end
                    k <= k + 1'b1;
                    if (k == num_vec - 1'b1) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= !fail && (err_cnt_o == '0);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_stim_checker.sv
// tb_inv_stim_checker: randomized and directed checks of the inverter stimulus checker
module tb_inv_stim_checker;

    localparam int         LAT_O  = 2;
    localparam int         LAT_NO = 1;
    localparam int         M      = 2;
    localparam int         NF     = 512;
    localparam logic [6:0] SEED   = 7'h5A;

    logic        clk = 0, rst_n = 0, start = 0, start4 = 0;
    logic [15:0] num_vec = 0;
    logic [3:0]  num_vec4 = 0;
    logic        out_i = 0, out_ni = 0, o4 = 0, no4 = 0;
    logic        stim, busy, done, pass;
    logic [15:0] err, first;
    logic        stim4, busy4, done4, pass4;
    logic [3:0]  err4, first4;

    int errors = 0, checks = 0;
    bit s_bits[NF + 8];
    bit o_ovr[NF], o_val[NF], no_ovr[NF], no_val[NF];
    int cyc = 0;
    bit arm = 0;

    always #5 clk = ~clk;

    inv_stim_checker #(.LAT_O(LAT_O), .LAT_NO(LAT_NO), .SEED(SEED), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_vec_i(num_vec),
        .out_i(out_i), .out_ni(out_ni), .stim_o(stim), .busy_o(busy), .done_o(done),
        .pass_o(pass), .err_cnt_o(err), .first_err_o(first)
    );

    inv_stim_checker #(.LAT_O(LAT_O), .LAT_NO(LAT_NO), .SEED(SEED), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .num_vec_i(num_vec4),
        .out_i(o4), .out_ni(no4), .stim_o(stim4), .busy_o(busy4), .done_o(done4),
        .pass_o(pass4), .err_cnt_o(err4), .first_err_o(first4)
    );

    // cycle number since the accepted start edge; stimulus bit index n is live during cycle n+1
    always @(posedge clk) cyc <= (start && arm) ? 1 : cyc + 1;

    // ideal clocked inverter with per-stimulus-index overrides for fault injection
    always @(posedge clk) out_i <= (cyc >= 1 && cyc <= NF && o_ovr[cyc-1]) ? o_val[cyc-1] : ~stim;
    always @(negedge clk) out_ni <= (cyc >= 1 && cyc <= NF && no_ovr[cyc-1]) ? no_val[cyc-1] : ~stim;

    // always-wrong partner: registers without inverting
    always @(posedge clk) o4 <= stim4;
    always @(negedge clk) no4 <= stim4;

    function automatic bit S(input int n);
        return s_bits[n + 6];
    endfunction

    task automatic build_prbs;
        for (int i = 0; i < 7; i++) s_bits[i] = SEED[6 - i];
        for (int j = 7; j < NF + 8; j++) s_bits[j] = s_bits[j - 6] ^ s_bits[j - 7];
    endtask

    task automatic clear_faults;
        for (int i = 0; i < NF; i++) begin
            o_ovr[i] = 0; o_val[i] = 0; no_ovr[i] = 0; no_val[i] = 0;
        end
    endtask

    // vector k pairs out_i with stimulus index k+M-LAT_O and out_ni with k+M-LAT_NO
    task automatic model(input int n, output int e, output int f);
        int io, ino;
        bit ob_o, ob_no;
        e = 0;
        f = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            io = k + M - LAT_O;
            ino = k + M - LAT_NO;
            ob_o = o_ovr[io] ? o_val[io] : ~S(io);
            ob_no = no_ovr[ino] ? no_val[ino] : ~S(ino);
            if (ob_o != ~S(io) || ob_no != ~S(ino)) begin
                if (e == 0) f = k;
                if (e < 65535) e++;
            end
        end
    endtask

    task automatic run_main(input int n, output int done_at, output int stim_bad, output bit busy1, output bit done_next);
        int t;
        @(negedge clk); num_vec = 16'(n); start = 1; arm = 1;
        @(negedge clk); start = 0; arm = 0;
        t = 1; busy1 = busy; stim_bad = 0; done_at = 0;
        while (t <= n + M + 20) begin
            if (t <= M + n && stim !== S(t - 1)) stim_bad++;
            if (done) begin done_at = t; break; end
            @(negedge clk); t++;
        end
        @(negedge clk); done_next = done;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++; if (stim !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_bits got stim=%b busy=%b done=%b pass=%b want 0000", stim, busy, done, pass); end
        checks++; if (err !== 16'h0 || first !== 16'hFFFF) begin errors++; $display("FAIL reset_counts got err=%h first=%h want 0000/ffff", err, first); end
        rst_n = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_ideal;
        int da, sb, e, f; bit b1, dn;
        clear_faults;
        run_main(100, da, sb, b1, dn);
        model(100, e, f);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL ideal_busy got %b want 1", b1); end
        checks++; if (da !== 1 + M + 100) begin errors++; $display("FAIL ideal_done_at got %0d want %0d", da, 1 + M + 100); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL ideal_stim_seq got %0d bad bits want 0", sb); end
        checks++; if (pass !== 1'b1 || err !== 16'(e) || first !== 16'(f)) begin errors++; $display("FAIL ideal_result got pass=%b err=%0d first=%h want 1 %0d %h", pass, err, first, e, f); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL ideal_done_pulse got done=%b one cycle later want 0", dn); end
    endtask

    task automatic test_single_fault;
        int da, sb, e, f; bit b1, dn;
        clear_faults;
        o_ovr[37] = 1; o_val[37] = 0;
        run_main(100, da, sb, b1, dn);
        model(100, e, f);
        checks++; if (da !== 1 + M + 100) begin errors++; $display("FAIL fault37_done_at got %0d want %0d", da, 1 + M + 100); end
        checks++; if (err !== 16'(e) || first !== 16'(f) || pass !== (e == 0)) begin errors++; $display("FAIL fault37_result got err=%0d first=%0d pass=%b want %0d %0d %b", err, first, pass, e, f, e == 0); end
    endtask

    task automatic test_stuck_out_n;
        int da, sb, e, f; bit b1, dn;
        clear_faults;
        for (int i = 0; i < NF; i++) begin no_ovr[i] = 1; no_val[i] = 1; end
        run_main(20, da, sb, b1, dn);
        model(20, e, f);
        checks++; if (da !== 1 + M + 20) begin errors++; $display("FAIL stuck_done_at got %0d want %0d", da, 1 + M + 20); end
        checks++; if (err !== 16'(e) || first !== 16'(f) || pass !== (e == 0)) begin errors++; $display("FAIL stuck_result got err=%0d first=%0d pass=%b want %0d %0d %b", err, first, pass, e, f, e == 0); end
    endtask

    task automatic test_zero_vectors;
        int da, sb, e, f; bit b1, dn;
        clear_faults;
        run_main(0, da, sb, b1, dn);
        model(0, e, f);
        checks++; if (da !== 1 + M) begin errors++; $display("FAIL zero_done_at got %0d want %0d", da, 1 + M); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL zero_stim_seq got %0d bad bits want 0", sb); end
        checks++; if (pass !== 1'b1 || err !== 16'(e) || first !== 16'(f)) begin errors++; $display("FAIL zero_result got pass=%b err=%0d first=%h want 1 %0d %h", pass, err, first, e, f); end
    endtask

    task automatic test_random;
        int n, da, sb, e, f; bit b1, dn;
        for (int it = 0; it < 4; it++) begin
            clear_faults;
            n = $urandom_range(1, 80);
            for (int i = 0; i < n + M; i++) begin
                if ($urandom_range(0, 15) == 0) begin o_ovr[i] = 1; o_val[i] = 1'($urandom); end
                if ($urandom_range(0, 15) == 0) begin no_ovr[i] = 1; no_val[i] = 1'($urandom); end
            end
            run_main(n, da, sb, b1, dn);
            model(n, e, f);
            checks++; if (da !== 1 + M + n) begin errors++; $display("FAIL rand%0d_done_at got %0d want %0d", it, da, 1 + M + n); end
            checks++; if (err !== 16'(e) || first !== 16'(f) || pass !== (e == 0)) begin errors++; $display("FAIL rand%0d_result n=%0d got err=%0d first=%0d pass=%b want %0d %0d %b", it, n, err, first, pass, e, f, e == 0); end
        end
    endtask

    task automatic test_reset_mid_run;
        int da, sb, dseen; bit b1, dn;
        clear_faults;
        @(negedge clk); num_vec = 100; start = 1; arm = 1;
        @(negedge clk); start = 0; arm = 0;
        repeat (M + 50) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
        rst_n = 0;
        #1;
        checks++; if (stim !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err !== 16'h0 || first !== 16'hFFFF) begin errors++; $display("FAIL midrun_reset got stim=%b busy=%b done=%b pass=%b err=%h first=%h want 0 0 0 0 0000 ffff", stim, busy, done, pass, err, first); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        dseen = 0;
        repeat (10) begin @(negedge clk); if (done) dseen++; end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL stale_done got %0d pulses want 0", dseen); end
        run_main(10, da, sb, b1, dn);
        checks++; if (da !== 1 + M + 10 || sb !== 0) begin errors++; $display("FAIL rerun_timing got done_at=%0d stim_bad=%0d want %0d 0", da, sb, 1 + M + 10); end
        checks++; if (pass !== 1'b1 || err !== 16'h0 || first !== 16'hFFFF) begin errors++; $display("FAIL rerun_result got pass=%b err=%0d first=%h want 1 0 ffff", pass, err, first); end
    endtask

    task automatic test_saturate;
        int t, da;
        @(negedge clk); num_vec4 = 4'd15; start4 = 1;
        @(negedge clk); start4 = 0;
        t = 1; da = 0;
        while (t <= 60) begin
            if (done4) begin da = t; break; end
            @(negedge clk); t++;
            start4 = (t == 8);
        end
        start4 = 0;
        checks++; if (da !== 1 + M + 15) begin errors++; $display("FAIL sat_done_at got %0d want %0d", da, 1 + M + 15); end
        checks++; if (err4 !== 4'hF || first4 !== 4'h0 || pass4 !== 1'b0) begin errors++; $display("FAIL sat_result got err=%h first=%h pass=%b want f 0 0", err4, first4, pass4); end
        repeat (3) @(negedge clk);
        checks++; if (err4 !== 4'hF) begin errors++; $display("FAIL sat_hold got err=%h want f", err4); end
    endtask

    initial begin
        build_prbs;
        clear_faults;
        test_reset;
        test_ideal;
        test_single_fault;
        test_stuck_out_n;
        test_zero_vectors;
        test_random;
        test_reset_mid_run;
        test_saturate;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
